// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer and synchronous flush
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    logic             s;
    logic [31:0]      imm32;
    logic             ill;
    logic [XLEN-1:0]  imm_x;
    logic             o_valid_q, o_valid_d, o_ill_q, o_ill_d;
    logic [XLEN-1:0]  o_imm_q, o_imm_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;
    logic             k_valid_q, k_valid_d, k_ill_q, k_ill_d;
    logic [XLEN-1:0]  k_imm_q, k_imm_d;
    logic [TAG_W-1:0] k_tag_q, k_tag_d;
    assign s = in_instr[31];
    // Every format fits in 32 bits; zero-extended ones keep bit 31 clear so one sign-extension serves all
    always_comb begin
        imm32 = '0;
        ill   = 1'b0;
        case (in_imm_src)
            3'b000:  imm32 = {{20{s}}, in_instr[31:20]};
            3'b001:  imm32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
            3'b010:  imm32 = {{19{s}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011:  imm32 = {in_instr[31:12], 12'h000};
            3'b100:  imm32 = {{11{s}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            3'b101:  imm32 = {27'b0, in_instr[19:15]};
            3'b110:  imm32 = {26'b0, (XLEN == 64) & in_instr[25], in_instr[24:20]};
            default: ill = 1'b1;
        endcase
    end
    assign imm_x = XLEN'($signed(imm32));
    // The skid entry is only ever filled while the output entry is held, so K valid implies O valid
    always_comb begin
        o_valid_d = o_valid_q;
        o_imm_d   = o_imm_q;
        o_tag_d   = o_tag_q;
        o_ill_d   = o_ill_q;
        k_valid_d = k_valid_q;
        k_imm_d   = k_imm_q;
        k_tag_d   = k_tag_q;
        k_ill_d   = k_ill_q;
        if (flush) begin
            o_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (k_valid_q) begin
            if (out_ready) begin
                o_imm_d   = k_imm_q;
                o_tag_d   = k_tag_q;
                o_ill_d   = k_ill_q;
                k_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (!o_valid_q || out_ready) begin
                o_valid_d = 1'b1;
                o_imm_d   = imm_x;
                o_tag_d   = in_tag;
                o_ill_d   = ill;
            end else begin
                k_valid_d = 1'b1;
                k_imm_d   = imm_x;
                k_tag_d   = in_tag;
                k_ill_d   = ill;
            end
        end else if (out_ready) begin
            o_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_imm_q   <= '0;
            o_tag_q   <= '0;
            o_ill_q   <= 1'b0;
            k_valid_q <= 1'b0;
            k_imm_q   <= '0;
            k_tag_q   <= '0;
            k_ill_q   <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_imm_q   <= o_imm_d;
            o_tag_q   <= o_tag_d;
            o_ill_q   <= o_ill_d;
            k_valid_q <= k_valid_d;
            k_imm_q   <= k_imm_d;
            k_tag_q   <= k_tag_d;
            k_ill_q   <= k_ill_d;
        end
    end
    assign in_ready    = !k_valid_q;
    assign out_valid   = o_valid_q;
    assign out_imm     = o_imm_q;
    assign out_tag     = o_tag_q;
    assign out_illegal = o_ill_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving XLEN=32 and XLEN=64 instances with shared stimulus
module tb_imm_gen_pipe;
    typedef struct packed {
        logic [63:0] e64;
        logic [31:0] e32;
        logic [31:0] tag;
        logic        ill;
    } ent_t;
    logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_tag = '0;
    logic [2:0]  in_imm_src = '0;
    logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    ent_t        q[$];
    int          checks = 0, passes = 0;
    always #5 clk = ~clk;
    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));
    // Arithmetic-shift formulation: field placed at the top of a 64-bit word, then shifted down
    function automatic ent_t model(input logic [31:0] i, input logic [2:0] src, input logic [31:0] tg);
        logic signed [63:0] v;
        ent_t e;
        case (src)
            3'd0:    v = $signed({i[31:20], 52'b0}) >>> 52;
            3'd1:    v = $signed({i[31:25], i[11:7], 52'b0}) >>> 52;
            3'd2:    v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}) >>> 51;
            3'd3:    v = $signed({i[31:12], 12'b0, 32'b0}) >>> 32;
            3'd4:    v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}) >>> 43;
            3'd5:    v = {59'b0, i[19:15]};
            3'd6:    v = {58'b0, i[25:20]};
            default: v = '0;
        endcase
        e.e64 = v;
        e.e32 = (src == 3'd6) ? {27'b0, i[24:20]} : v[31:0];
        e.tag = tg;
        e.ill = (src == 3'd7);
        return e;
    endfunction
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tg,
                        input logic ordy, input logic fl, input ent_t e, output logic got, output ent_t x);
        @(negedge clk);
        in_valid = v; in_instr = ins; in_imm_src = src; in_tag = tg; out_ready = ordy; flush = fl;
        #1;
        got = 1'b0;
        x = '0;
        if (fl) q.delete();
        else begin
            if (ov32 && ordy) begin
                got = 1'b1;
                x = (q.size() > 0) ? q.pop_front() : '1;
            end
            if (v && rdy32) q.push_back(e);
        end
    endtask
    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({ov32, imm32, tag32, ill32, ov64, imm64, tag64, ill64} !== '0)
            $display("FAIL reset_outs: v32=%b imm32=%h tag32=%h ill32=%b v64=%b imm64=%h tag64=%h ill64=%b, want all zero",
                     ov32, imm32, tag32, ill32, ov64, imm64, tag64, ill64);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({rdy32, rdy64} !== 2'b11) $display("FAIL reset_ready: in_ready=%b%b, want 11", rdy32, rdy64);
        else passes++;
    endtask
    task automatic test_formats();
        logic [31:0] ti[9];
        logic [2:0]  ts[9];
        logic [31:0] t32[9];
        logic [63:0] t64[9];
        logic        got;
        ent_t        x, e;
        int          n = 0, first = -1, k;
        ti  = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'h123452B7, 32'h800002B7,
                32'h03F09093, 32'h000F8073, 32'hFE000EE3, 32'h12345678};
        ts  = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd3, 3'd6, 3'd5, 3'd2, 3'd7};
        t32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h80000000,
                32'h0000001F, 32'h0000001F, 32'hFFFFFFFC, 32'h00000000};
        t64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000,
                64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h000000000000001F, 64'hFFFFFFFFFFFFFFFC, 64'h0};
        for (int i = 0; i < 13; i++) begin
            k = (i < 9) ? i : 0;
            e = '{t64[k], t32[k], 32'(100 + k), ts[k] == 3'd7};
            step(i < 9, ti[k], ts[k], 32'(100 + k), 1'b1, 1'b0, e, got, x);
            if (got) begin
                if (first < 0) first = i;
                n++;
                checks++;
                if ({imm32, tag32, ill32, imm64, tag64, ill64, ov64} !== {x.e32, x.tag, x.ill, x.e64, x.tag, x.ill, 1'b1})
                    $display("FAIL fmt: imm32=%h tag=%h ill=%b imm64=%h v64=%b, want imm32=%h tag=%h ill=%b imm64=%h",
                             imm32, tag32, ill32, imm64, ov64, x.e32, x.tag, x.ill, x.e64);
                else passes++;
            end
        end
        checks++;
        if (first != 1 || n != 9) $display("FAIL fmt_latency: first output step=%0d count=%0d, want 1 and 9", first, n);
        else passes++;
    endtask
    task automatic test_backpressure();
        logic        got, sent3 = 1'b0;
        ent_t        x, e1;
        int          n = 0, idx[3];
        logic [31:0] a = 32'hABC00013, b = 32'h7FF0A023, c = 32'h00C0006F;
        e1 = model(a, 3'd0, 32'd1);
        step(1'b1, a, 3'd0, 32'd1, 1'b0, 1'b0, e1, got, x);
        step(1'b1, b, 3'd1, 32'd2, 1'b0, 1'b0, model(b, 3'd1, 32'd2), got, x);
        step(1'b1, c, 3'd4, 32'd3, 1'b0, 1'b0, model(c, 3'd4, 32'd3), got, x);
        checks++;
        if ({rdy32, rdy64} !== 2'b00) $display("FAIL bp_ready: in_ready=%b%b after tag 2, want 00", rdy32, rdy64);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, c, 3'd4, 32'd3, 1'b0, 1'b0, model(c, 3'd4, 32'd3), got, x);
            checks++;
            if ({ov32, imm32, tag32, ov64, imm64, tag64, rdy32} !== {1'b1, e1.e32, 32'd1, 1'b1, e1.e64, 32'd1, 1'b0})
                $display("FAIL bp_stable: v=%b imm32=%h tag=%h imm64=%h rdy=%b, want v=1 imm32=%h tag=1 imm64=%h rdy=0",
                         ov32, imm32, tag32, imm64, rdy32, e1.e32, e1.e64);
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            step(!sent3, c, 3'd4, 32'd3, 1'b1, 1'b0, model(c, 3'd4, 32'd3), got, x);
            if (!sent3 && rdy32) sent3 = 1'b1;
            if (got) begin
                if (n < 3) idx[n] = i;
                n++;
                checks++;
                if ({imm32, tag32, ill32, imm64, tag64, ov64} !== {x.e32, 32'(n), x.ill, x.e64, 32'(n), 1'b1})
                    $display("FAIL bp_order: tag=%h imm32=%h imm64=%h, want tag=%0d imm32=%h imm64=%h",
                             tag32, imm32, imm64, n, x.e32, x.e64);
                else passes++;
            end
        end
        checks++;
        if (n != 3 || idx[2] - idx[0] != 2) $display("FAIL bp_gaps: outputs=%0d span=%0d, want 3 and 2", n, idx[2] - idx[0]);
        else passes++;
    endtask
    task automatic test_flush();
        logic got;
        ent_t x;
        int   leak = 0, n = 0;
        step(1'b1, 32'h00100093, 3'd0, 32'd10, 1'b0, 1'b0, model(32'h00100093, 3'd0, 32'd10), got, x);
        step(1'b1, 32'h000012B7, 3'd3, 32'd11, 1'b0, 1'b0, model(32'h000012B7, 3'd3, 32'd11), got, x);
        step(1'b1, 32'h0080006F, 3'd4, 32'd12, 1'b1, 1'b1, model(32'h0080006F, 3'd4, 32'd12), got, x);
        step(1'b0, 32'h0, 3'd0, 32'd0, 1'b1, 1'b0, '0, got, x);
        checks++;
        if ({ov32, ov64, rdy32, rdy64} !== 4'b0011)
            $display("FAIL flush_state: out_valid=%b%b in_ready=%b%b, want 00 11", ov32, ov64, rdy32, rdy64);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 3'd0, 32'd0, 1'b1, 1'b0, '0, got, x);
            if (got || ov64) leak++;
        end
        checks++;
        if (leak != 0) $display("FAIL flush_leak: %0d stale outputs after flush, want 0", leak);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 32'hFFF0C513, 3'd6, 32'd13, 1'b1, 1'b0, model(32'hFFF0C513, 3'd6, 32'd13), got, x);
            if (got) begin
                n++;
                checks++;
                if ({imm32, tag32, imm64, tag64} !== {x.e32, 32'd13, x.e64, 32'd13})
                    $display("FAIL flush_after: tag=%h imm32=%h imm64=%h, want tag=13 imm32=%h imm64=%h",
                             tag32, imm32, imm64, x.e32, x.e64);
                else passes++;
            end
        end
        checks++;
        if (n != 1) $display("FAIL flush_after_cnt: %0d outputs, want 1", n);
        else passes++;
    endtask
    task automatic test_random();
        logic        got, v, fl;
        logic [31:0] ins, tg;
        logic [2:0]  src;
        ent_t        x;
        int          bad = 0, n = 0;
        for (int i = 0; i < 320; i++) begin
            v   = (i < 300) && ($urandom_range(0, 3) != 0);
            fl  = (i < 300) && ($urandom_range(0, 39) == 0);
            ins = $urandom;
            src = 3'($urandom_range(0, 7));
            tg  = $urandom;
            step(v, ins, src, tg, (i >= 300) || ($urandom_range(0, 3) != 0), fl, model(ins, src, tg), got, x);
            if (got) begin
                n++;
                checks++;
                if ({imm32, tag32, ill32, imm64, tag64, ill64, ov64} !== {x.e32, x.tag, x.ill, x.e64, x.tag, x.ill, 1'b1}) begin
                    bad++;
                    if (bad < 6)
                        $display("FAIL rand: imm32=%h tag=%h ill=%b imm64=%h, want imm32=%h tag=%h ill=%b imm64=%h",
                                 imm32, tag32, ill32, imm64, x.e32, x.tag, x.ill, x.e64);
                end else passes++;
            end
        end
        checks++;
        if (q.size() != 0 || n < 50) $display("FAIL rand_drain: %0d entries left, %0d outputs, want 0 and >=50", q.size(), n);
        else passes++;
    endtask
    task automatic test_reset_mid();
        logic got;
        ent_t x;
        step(1'b1, 32'h00500093, 3'd0, 32'd20, 1'b0, 1'b0, model(32'h00500093, 3'd0, 32'd20), got, x);
        step(1'b1, 32'h00600093, 3'd0, 32'd21, 1'b0, 1'b0, model(32'h00600093, 3'd0, 32'd21), got, x);
        step(1'b0, 32'h0, 3'd0, 32'd0, 1'b0, 1'b0, '0, got, x);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov32, ov64} !== 2'b00) $display("FAIL rst_mid: out_valid=%b%b during reset, want 00", ov32, ov64);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        checks++;
        if ({rdy32, rdy64, ov32, ov64} !== 4'b1100)
            $display("FAIL rst_mid_rel: in_ready=%b%b out_valid=%b%b, want 11 00", rdy32, rdy64, ov32, ov64);
        else passes++;
    endtask
    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
